// File: rtl/stereo_i2s_tx.sv
// stereo_i2s_tx: holds one signed 16-bit L/R pair and serialises it as standard
// I2S (32 bclk per frame, MSB first, data lagging lrclk by one bclk).
module stereo_i2s_tx #(
  parameter int BCLK_HALF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_L,
  input  logic [15:0] in_R,
  input  logic        in_ready,
  output logic        frame_req,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun,
  output logic        overrun
);

  localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  // bit-clock generation state
  logic [DIV_W-1:0] div_r, div_nxt_s;
  logic             bclk_r, bclk_nxt_s;
  logic             lrclk_r, lrclk_nxt_s;
  logic [4:0]       slot_r, slot_nxt_s;

  // data path state
  logic [15:0]      hold_left_r, hold_left_nxt_s;
  logic [15:0]      hold_right_r, hold_right_nxt_s;
  logic             hold_valid_r, hold_valid_nxt_s;
  logic [31:0]      shift_r, shift_nxt_s;
  logic             sdata_r, sdata_nxt_s;

  // status pulses
  logic             frame_req_r, frame_req_nxt_s;
  logic             underrun_r, underrun_nxt_s;
  logic             overrun_r, overrun_nxt_s;

  logic             div_wrap_s;
  logic             fall_s;
  logic             load_s;

  // Event decode: a fall event is the cycle whose edge drives bclk 1->0.
  always_comb begin
    div_wrap_s = (div_r == DIV_LAST);
    fall_s     = div_wrap_s & bclk_r;
    load_s     = fall_s & (slot_r == 5'd31);
  end

  // Next state of the divider, bit clock, slot counter and word select.
  always_comb begin
    div_nxt_s   = div_r;
    bclk_nxt_s  = bclk_r;
    slot_nxt_s  = slot_r;
    lrclk_nxt_s = lrclk_r;
    if (div_wrap_s) begin
      div_nxt_s  = {DIV_W{1'b0}};
      bclk_nxt_s = ~bclk_r;
    end else begin
      div_nxt_s  = div_r + DIV_W'(1);
    end
    if (fall_s) begin
      slot_nxt_s  = slot_r + 5'd1;
      lrclk_nxt_s = slot_nxt_s[4];
    end else begin
      slot_nxt_s  = slot_r;
    end
  end

  // Next state of the shifter, output delay flop and holding buffer.
  always_comb begin
    shift_nxt_s      = shift_r;
    sdata_nxt_s      = sdata_r;
    hold_left_nxt_s  = hold_left_r;
    hold_right_nxt_s = hold_right_r;
    hold_valid_nxt_s = hold_valid_r;
    // sdata lags the shifter by one slot, giving the I2S one-bit delay
    if (fall_s) begin
      sdata_nxt_s = shift_r[31];
    end else begin
      sdata_nxt_s = sdata_r;
    end
    if (load_s) begin
      if (hold_valid_r) begin
        shift_nxt_s = {hold_left_r, hold_right_r};
      end else begin
        shift_nxt_s = 32'd0;
      end
    end else if (fall_s) begin
      shift_nxt_s = {shift_r[30:0], 1'b0};
    end else begin
      shift_nxt_s = shift_r;
    end
    // a capture coinciding with a load refills the buffer just emptied
    if (in_ready) begin
      hold_left_nxt_s  = in_L;
      hold_right_nxt_s = in_R;
      hold_valid_nxt_s = 1'b1;
    end else if (load_s) begin
      hold_valid_nxt_s = 1'b0;
    end else begin
      hold_valid_nxt_s = hold_valid_r;
    end
  end

  // Next state of the one-cycle status pulses.
  always_comb begin
    frame_req_nxt_s = load_s;
    underrun_nxt_s  = load_s & ~hold_valid_r;
    overrun_nxt_s   = in_ready & hold_valid_r & ~load_s;
  end

  // Timing registers: divider, bit clock, slot counter, word select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r   <= {DIV_W{1'b0}};
      bclk_r  <= 1'b0;
      slot_r  <= 5'd31;
      lrclk_r <= 1'b0;
    end else begin
      div_r   <= div_nxt_s;
      bclk_r  <= bclk_nxt_s;
      slot_r  <= slot_nxt_s;
      lrclk_r <= lrclk_nxt_s;
    end
  end

  // Data registers: holding buffer, shifter and serial output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_left_r  <= 16'd0;
      hold_right_r <= 16'd0;
      hold_valid_r <= 1'b0;
      shift_r      <= 32'd0;
      sdata_r      <= 1'b0;
    end else begin
      hold_left_r  <= hold_left_nxt_s;
      hold_right_r <= hold_right_nxt_s;
      hold_valid_r <= hold_valid_nxt_s;
      shift_r      <= shift_nxt_s;
      sdata_r      <= sdata_nxt_s;
    end
  end

  // Status pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_req_r <= 1'b0;
      underrun_r  <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_req_r <= frame_req_nxt_s;
      underrun_r  <= underrun_nxt_s;
      overrun_r   <= overrun_nxt_s;
    end
  end

  assign bclk      = bclk_r;
  assign lrclk     = lrclk_r;
  assign sdata     = sdata_r;
  assign frame_req = frame_req_r;
  assign underrun  = underrun_r;
  assign overrun   = overrun_r;

endmodule
